mem_scheduler: RTL

Byte-serial memory scheduler between the instruction cache and the load/store buffer (LSB). Owns the single 8-bit RAM port: grants one requester at a time with round-robin fairness, serialises line refills and 1/2/4-byte loads and stores into per-byte bus cycles, and gates IO-region writes on `io_buffer_full`. Sits between the cache/LSB and the top-level RAM/IO pins.

---
 rtl/mem_scheduler_pkg.sv | 35 +++
 rtl/mem_scheduler_rr_arb2.sv | 34 +++
 rtl/mem_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_scheduler_pkg.sv
// Shared definitions for the byte-serial memory scheduler: FSM states,
// access size codes, IO region decode and requester identifiers.
package mem_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IC_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Address bits [17:16] equal to this value select the IO region.
    localparam logic [1:0] IO_SEL = 2'b11;

    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // Byte count of a load/store; the illegal code 3 behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [1:0] sel);
        return sel == IO_SEL;
    endfunction

endpackage

// File: rtl/mem_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester that was not
// granted last wins; the history only advances when a grant is issued.
module rr_arb2
    import mem_scheduler_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic en,
    input  logic req_ic,
    input  logic req_ls,
    output logic grant_ic,
    output logic grant_ls
);

    logic last_grant;

    // Grant decision from the current requests and the last winner.
    always_comb begin
        grant_ls = en && req_ls && (!req_ic || last_grant == REQ_IC);
        grant_ic = en && req_ic && !grant_ls;
    end

    // Remember who was served; icache after reset so the LSB wins the first tie.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_grant <= REQ_IC;
        end else if (grant_ic) begin
            last_grant <= REQ_IC;
        end else if (grant_ls) begin
            last_grant <= REQ_LS;
        end
    end

endmodule

// File: rtl/mem_scheduler.sv
// Byte-serial scheduler for the single 8-bit RAM port, shared between the
// icache refill path and the load/store buffer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer; grant taken here (not in a done cycle)
// ST_IC_RD | icache line refill, one byte address per cycle
// ST_LS_RD | 1/2/4-byte load
// ST_LS_WR | 1/2/4-byte store, IO stores gated by io_buffer_full
module mem_scheduler
    import mem_scheduler_pkg::*;
#(
    parameter int LINE_BYTES = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_in,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic                    ic_req,
    input  logic [31:0]             ic_addr,
    output logic                    ic_done,
    output logic [8*LINE_BYTES-1:0] ic_data,
    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [1:0]              ls_size,
    input  logic [31:0]             ls_addr,
    input  logic [31:0]             ls_wdata,
    output logic                    ls_done,
    output logic [31:0]             ls_rdata
);

    localparam int CW = $clog2(LINE_BYTES) + 1;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           len;
    logic [CW-1:0]           cnt_nxt;
    logic [CW-1:0]           cnt_m1;
    logic [31:0]             base;
    logic                    io_q;
    logic                    wr_act;
    logic [8*LINE_BYTES-1:0] buf_q;
    logic [8*LINE_BYTES-1:0] line_cap;
    logic [7:0]              cap_byte;
    logic [7:0]              din_q;
    logic                    stall_q;
    logic                    arb_en;
    logic                    grant_ic;
    logic                    grant_ls;

    assign arb_en = rdy_in && (state == ST_IDLE) && !clear_in && !ic_done && !ls_done;
    assign mem_wr = wr_act && rdy_in && !(io_q && io_buffer_full);

    rr_arb2 u_arb (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en       (arb_en),
        .req_ic   (ic_req),
        .req_ls   (ls_req),
        .grant_ic (grant_ic),
        .grant_ls (grant_ls)
    );

    // The RAM keeps answering while rdy_in is low, so the byte that was due in
    // the first stalled cycle is parked here and used when the stall ends.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            din_q   <= 8'h00;
            stall_q <= 1'b0;
        end else if (!rdy_in) begin
            if (!stall_q) begin
                din_q <= mem_din;
            end
            stall_q <= 1'b1;
        end else begin
            stall_q <= 1'b0;
        end
    end

    // Shift buffer with the byte arriving this cycle merged in at cnt-1.
    always_comb begin
        cap_byte = stall_q ? din_q : mem_din;
        cnt_nxt  = cnt + CW'(1);
        cnt_m1   = cnt - CW'(1);
        line_cap = buf_q;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (cnt != '0 && cnt_m1 == CW'(i)) begin
                line_cap[8*i +: 8] = cap_byte;
            end
        end
    end

    // Transfer sequencer: grant, per-byte bus cycles, completion and abort.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            len      <= '0;
            base     <= 32'h0;
            io_q     <= 1'b0;
            wr_act   <= 1'b0;
            buf_q    <= '0;
            mem_a    <= 32'h0;
            mem_dout <= 8'h00;
            ic_done  <= 1'b0;
            ls_done  <= 1'b0;
            ic_data  <= '0;
            ls_rdata <= 32'h0;
        end else if (rdy_in) begin
            ic_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_ic) begin
                        state <= ST_IC_RD;
                        base  <= ic_addr;
                        mem_a <= ic_addr;
                        len   <= CW'(LINE_BYTES);
                        io_q  <= 1'b0;
                        cnt   <= '0;
                        buf_q <= '0;
                    end else if (grant_ls) begin
                        state  <= ls_we ? ST_LS_WR : ST_LS_RD;
                        base   <= ls_addr;
                        mem_a  <= ls_addr;
                        len    <= CW'(size_bytes(ls_size));
                        io_q   <= is_io(ls_addr[17:16]);
                        cnt    <= '0;
                        buf_q  <= '0;
                        wr_act <= ls_we;
                        if (ls_we) begin
                            mem_dout <= ls_wdata[7:0];
                        end
                    end
                end
                ST_IC_RD, ST_LS_RD: begin
                    // IO loads have side effects in the device, so they finish.
                    if (clear_in && !(state == ST_LS_RD && io_q)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == len) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        buf_q <= line_cap;
                        if (state == ST_IC_RD) begin
                            ic_data <= line_cap;
                            ic_done <= 1'b1;
                        end else begin
                            ls_rdata <= line_cap[31:0];
                            ls_done  <= 1'b1;
                        end
                    end else begin
                        buf_q <= line_cap;
                        cnt   <= cnt_nxt;
                        if (cnt_nxt < len) begin
                            mem_a <= base + 32'(cnt_nxt);
                        end
                    end
                end
                ST_LS_WR: begin
                    if (mem_wr) begin
                        if (cnt_nxt == len) begin
                            state   <= ST_IDLE;
                            cnt     <= '0;
                            wr_act  <= 1'b0;
                            ls_done <= 1'b1;
                        end else begin
                            cnt      <= cnt_nxt;
                            mem_a    <= base + 32'(cnt_nxt);
                            mem_dout <= ls_wdata[{cnt_nxt[1:0], 3'b000} +: 8];
                        end
                    end
                end
            endcase
        end
    end

endmodule
